// File: rtl/rx_multilane_pkg.sv
// Shared definitions for the multi-lane flit receiver: flit field sizes,
// receiver FSM states and small elaboration-time helpers.
package rx_multilane_pkg;

  localparam int HDR_SZ         = 2;
  localparam int PL_SZ          = 8;
  localparam int ADDR_SZ        = 4;
  localparam int FLIT_W_DEFAULT = HDR_SZ + PL_SZ + ADDR_SZ;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_PAR  = 2'd2
  } rx_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width of a counter/pointer addressing n items; never below one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_multilane_if.sv
// Link/consumer-side signal bundle of the flit receiver. The slave modport is
// the receiver; the master modport is the transmitter plus downstream consumer.
interface rx_multilane_if
  import rx_multilane_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int FLIT_W = FLIT_W_DEFAULT,
  parameter int OCC_W  = 2
);

  logic [LANES-1:0]  serial_in;
  logic              channel_busy;
  logic              valid;
  logic              item_read;
  logic [FLIT_W-1:0] parallel_out;
  logic              parity_err;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output serial_in, item_read,
    input  channel_busy, valid, parallel_out, parity_err, occupancy
  );

  modport slave (
    input  serial_in, item_read,
    output channel_busy, valid, parallel_out, parity_err, occupancy
  );

endinterface

// File: rtl/rx_fifo.sv
// Synchronous FIFO for received flits: any DEPTH, wrapping pointers, head
// forced to zero while empty, simultaneous read and write at any fill level.
module rx_fifo
  import rx_multilane_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int FLIT_W = FLIT_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FLIT_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [FLIT_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       not_empty
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = width_of(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              do_wr, do_rd;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    do_rd    = rd_en && (occ_q != '0);
    do_wr    = wr_en && ((occ_q != OCC_W'(DEPTH)) || do_rd);
    wr_ptr_d = do_wr ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? bump(rd_ptr_q) : rd_ptr_q;
    unique case ({do_wr, do_rd})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: storage is not reset; the empty-head mux hides stale entries.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign not_empty = (occ_q != '0);
  assign occupancy = occ_q;
  assign head      = not_empty ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/rx_multilane.sv
// Serial flit receiver: LANES-wide link with start-bit framing, optional even
// parity beat, and a DEPTH-entry output FIFO with busy back-pressure upstream.
module rx_multilane
  import rx_multilane_pkg::*;
#(
  parameter int    FLIT_W    = FLIT_W_DEFAULT,
  parameter int    LANES     = 1,
  parameter int    DEPTH     = 2,
  parameter bit    PARITY_EN = 1'b0,
  parameter bit    DROP_BAD  = 1'b1,
  parameter int    routerid  = -1,
  parameter string port      = "unknown"
) (
  input logic           clk,
  input logic           reset,
  rx_multilane_if.slave bus
);

  localparam int BEATS  = ceil_div(FLIT_W, LANES);
  localparam int BEAT_W = width_of(BEATS);
  localparam int OCC_W  = $clog2(DEPTH + 1);

  if (FLIT_W < 1 || LANES < 1 || LANES > FLIT_W || DEPTH < 1) begin : g_bad_cfg
    $error("rx_multilane: illegal FLIT_W/LANES/DEPTH combination");
  end
  if (routerid < -1 || port == "") begin : g_bad_tag
    $error("rx_multilane: malformed debug tag");
  end

  rx_state_e         state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [FLIT_W-1:0] asm_q, asm_d;
  logic              perr_q, perr_d;
  logic              wr_en;
  logic [FLIT_W-1:0] wr_data;
  logic [OCC_W-1:0]  occ;
  logic              full;
  logic              head_valid;
  logic [FLIT_W-1:0] head;

  assign full = (occ == OCC_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    perr_d  = 1'b0;
    wr_en   = 1'b0;
    wr_data = asm_q;
    unique case (state_q)
      RX_IDLE: begin
        // A start bit is only taken when the FIFO can hold the finished flit.
        if (bus.serial_in[0] && !full) begin
          state_d = RX_DATA;
          beat_d  = '0;
          asm_d   = '0;
        end
      end
      RX_DATA: begin
        for (int i = 0; i < FLIT_W; i++) begin
          if (BEAT_W'(i / LANES) == beat_q) asm_d[i] = bus.serial_in[i % LANES];
        end
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          if (PARITY_EN) begin
            state_d = RX_PAR;
          end else begin
            state_d = RX_IDLE;
            wr_en   = 1'b1;
            wr_data = asm_d;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      RX_PAR: begin
        state_d = RX_IDLE;
        perr_d  = (bus.serial_in[0] != ^asm_q);
        wr_en   = !(perr_d && DROP_BAD);
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      beat_q  <= '0;
      asm_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      perr_q  <= perr_d;
    end
  end

  rx_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (bus.item_read),
    .head      (head),
    .occupancy (occ),
    .not_empty (head_valid)
  );

  assign bus.channel_busy = (state_q != RX_IDLE) || full;
  assign bus.valid        = head_valid;
  assign bus.parallel_out = head;
  assign bus.occupancy    = occ;
  assign bus.parity_err   = perr_q;

endmodule
